// File: rtl/operand_stage.sv
// Operand stage of a small RV32 pipeline.
// Decodes a subset of RV32I ALU instructions (ADD, SUB, AND, OR, ADDI, ANDI,
// ORI), reads operands from a 32 x 32-bit register file with optional
// same-cycle writeback forwarding, and presents the decoded operation to the
// ALU through a valid/ready output register. Unsupported encodings are dropped
// and flagged with a one-cycle illegal pulse.
module operand_stage #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction input handshake
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  // writeback port
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  // ALU output handshake
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic [2:0]  alu_func,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [4:0]  alu_rd,
  output logic        illegal
);

  // ALU operation codes presented on alu_func.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_func_e;

  // Major opcodes and funct fields recognised by the decoder.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm_i;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] regs_q [32];
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  // Register file write: one writeback per cycle, x0 is never written.
  // NOTE: this storage is reset on purpose, because every register must read 0
  // after reset; a plain RAM would normally be left unreset so it can map to
  // memory macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en && (wb_rd != 5'd0)) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Operand read: combinational, optional forwarding of a same-cycle
  // writeback, x0 forced to zero last so it wins over any forwarding.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    rs1_val = regs_q[rs1];
    rs2_val = regs_q[rs2];
    if (BYPASS && wb_en && (wb_rd == rs1)) begin
      rs1_val = wb_data;
    end
    if (BYPASS && wb_en && (wb_rd == rs2)) begin
      rs2_val = wb_data;
    end
    if (rs1 == 5'd0) begin
      rs1_val = '0;
    end
    if (rs2 == 5'd0) begin
      rs2_val = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic      dec_legal;
  logic      dec_use_imm;
  alu_func_e dec_func;

  // Decode the supported R-type and I-type ALU instructions; anything else
  // leaves dec_legal low.
  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_func    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD: begin
              dec_legal = 1'b1;
              dec_func  = ALU_ADD;
            end
            F3_AND: begin
              dec_legal = 1'b1;
              dec_func  = ALU_AND;
            end
            F3_OR: begin
              dec_legal = 1'b1;
              dec_func  = ALU_OR;
            end
            default: dec_legal = 1'b0;
          endcase
        end else if ((funct7 == F7_ALT) && (funct3 == F3_ADD)) begin
          dec_legal = 1'b1;
          dec_func  = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        dec_use_imm = 1'b1;
        case (funct3)
          F3_ADD: begin
            dec_legal = 1'b1;
            dec_func  = ALU_ADD;
          end
          F3_AND: begin
            dec_legal = 1'b1;
            dec_func  = ALU_AND;
          end
          F3_OR: begin
            dec_legal = 1'b1;
            dec_func  = ALU_OR;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  logic        alu_valid_q, alu_valid_d;
  alu_func_e   alu_func_q,  alu_func_d;
  logic [31:0] alu_op1_q,   alu_op1_d;
  logic [31:0] alu_op2_q,   alu_op2_d;
  logic [4:0]  alu_rd_q,    alu_rd_d;
  logic        illegal_q,   illegal_d;
  logic        accept;
  logic        load;

  // The stage can take a new instruction whenever the output register is
  // empty or is being drained this cycle.
  assign instr_ready = !alu_valid_q || alu_ready;
  assign accept      = instr_valid && instr_ready;
  assign load        = accept && dec_legal;

  // Next-state of the output register: a legal accept overwrites it (also
  // when the held operation drains in the same cycle), a drain alone empties
  // it, otherwise everything holds so operands stay stable under a stall.
  always_comb begin
    alu_valid_d = alu_valid_q;
    alu_func_d  = alu_func_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_rd_d    = alu_rd_q;
    illegal_d   = accept && !dec_legal;
    if (load) begin
      alu_valid_d = 1'b1;
      alu_func_d  = dec_func;
      alu_op1_d   = rs1_val;
      alu_op2_d   = dec_use_imm ? imm_i : rs2_val;
      alu_rd_d    = rd;
    end else if (alu_ready) begin
      alu_valid_d = 1'b0;
    end
  end

  // Output register update; reset discards any held operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid_q <= 1'b0;
      alu_func_q  <= ALU_ADD;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_rd_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      alu_valid_q <= alu_valid_d;
      alu_func_q  <= alu_func_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_rd_q    <= alu_rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_func  = alu_func_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_rd    = alu_rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_operand_stage.sv
// Testbench for operand_stage. Two instances share all inputs: dut_a forwards
// same-cycle writebacks, dut_b does not. Stimulus pushes hand-computed
// expectations into a queue; a monitor on the falling edge pops and compares
// whenever an operation is handed to the ALU.
module tb_operand_stage;

  typedef struct {
    logic [2:0]  func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [31:0] op1_nb;   // expected operands for the non-forwarding instance
    logic [31:0] op2_nb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        alu_ready = 1'b1;

  logic        ready_a, valid_a, ill_a;
  logic [2:0]  func_a;
  logic [31:0] op1_a, op2_a;
  logic [4:0]  rd_a;
  logic        ready_b, valid_b, ill_b;
  logic [2:0]  func_b;
  logic [31:0] op1_b, op2_b;
  logic [4:0]  rd_b;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ill_exp = 0;
  int   ill_seen_a = 0;
  int   ill_seen_b = 0;

  operand_stage #(.BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(ready_a), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_valid(valid_a), .alu_ready(alu_ready), .alu_func(func_a),
    .alu_op1(op1_a), .alu_op2(op2_a), .alu_rd(rd_a), .illegal(ill_a)
  );

  operand_stage #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(ready_b), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_valid(valid_b), .alu_ready(alu_ready), .alu_func(func_b),
    .alu_op1(op1_b), .alu_op2(op2_b), .alu_rd(rd_b), .illegal(ill_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic exp_t mk(input logic [2:0] func, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [4:0] rd);
    exp_t e;
    e.func = func; e.op1 = op1; e.op2 = op2; e.rd = rd;
    e.op1_nb = op1; e.op2_nb = op2;
    return e;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  // Present an instruction until it is accepted; instr_valid stays high so
  // consecutive calls run back to back.
  task automatic issue(input logic [31:0] ins, input logic legal, input exp_t e);
    int waited = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!ready_a && waited < 20) begin
      tick();
      waited++;
    end
    if (!ready_a) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: instr 0x%08h not accepted after %0d cycles", ins, waited);
      instr_valid = 1'b0;
      return;
    end
    if (legal) exp_q.push_back(e);
    else ill_exp++;
    tick();
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    tick();
  endtask

  // Monitor: compare each handed-over operation, check stability under stall,
  // and count illegal pulses.
  exp_t        mon_e;
  logic        hold_v = 1'b0;
  logic [2:0]  hold_func;
  logic [31:0] hold_op1, hold_op2;
  logic [4:0]  hold_rd;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (ill_a) ill_seen_a++;
      if (ill_b) ill_seen_b++;
      if (valid_a && alu_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_op: func=%0d op1=0x%08h op2=0x%08h rd=%0d, expected none",
                   func_a, op1_a, op2_a, rd_a);
        end else begin
          mon_e = exp_q.pop_front();
          check("func_a", 32'(func_a), 32'(mon_e.func));
          check("op1_a",  op1_a, mon_e.op1);
          check("op2_a",  op2_a, mon_e.op2);
          check("rd_a",   32'(rd_a), 32'(mon_e.rd));
          check("valid_b", 32'(valid_b), 32'd1);
          check("func_b", 32'(func_b), 32'(mon_e.func));
          check("op1_b",  op1_b, mon_e.op1_nb);
          check("op2_b",  op2_b, mon_e.op2_nb);
          check("rd_b",   32'(rd_b), 32'(mon_e.rd));
        end
      end
      if (valid_a && !alu_ready) begin
        if (hold_v) begin
          check("hold_func", 32'(func_a), 32'(hold_func));
          check("hold_op1",  op1_a, hold_op1);
          check("hold_op2",  op2_a, hold_op2);
          check("hold_rd",   32'(rd_a), 32'(hold_rd));
        end
        hold_v = 1'b1;
        hold_func = func_a; hold_op1 = op1_a; hold_op2 = op2_a; hold_rd = rd_a;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    // Reset state.
    #3;
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_illegal", 32'(ill_a), 32'd0);
    check("rst_op1", op1_a, 32'd0);
    check("rst_op2", op2_a, 32'd0);
    check("rst_func", 32'(func_a), 32'd0);
    check("rst_rd", 32'(rd_a), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("ready_after_rst", 32'(ready_a), 32'd1);

    // Basic R-type and I-type decode, back to back.
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd3);
    write_reg(5'd7, 32'h1234_5678);
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1, mk(3'b000, 32'd5, 32'd3, 5'd3));
    issue(i_type(12'hFFF, 5'd1, 3'b000, 5'd4), 1'b1, mk(3'b000, 32'd5, 32'hFFFF_FFFF, 5'd4));
    issue(i_type(12'h0F0, 5'd0, 3'b110, 5'd5), 1'b1, mk(3'b011, 32'd0, 32'h0000_00F0, 5'd5));
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd9), 1'b1, mk(3'b010, 32'd5, 32'd3, 5'd9));
    issue(i_type(12'h800, 5'd1, 3'b111, 5'd17), 1'b1, mk(3'b010, 32'd5, 32'hFFFF_F800, 5'd17));
    idle();
    check("drained_valid", 32'(valid_a), 32'd0);

    // Stall: SUB held for three cycles while x1 is rewritten underneath it.
    issue(r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd6), 1'b1, mk(3'b001, 32'd5, 32'd3, 5'd6));
    alu_ready = 1'b0;
    instr_valid = 1'b0;
    write_reg(5'd1, 32'd100);
    check("stall_ready_a", 32'(ready_a), 32'd0);
    check("stall_ready_b", 32'(ready_b), 32'd0);
    check("stall_func", 32'(func_a), 32'd1);
    tick();
    check("stall_op1", op1_a, 32'd5);
    tick();
    check("stall_ready_3", 32'(ready_a), 32'd0);
    alu_ready = 1'b1;
    tick();
    check("valid_cleared", 32'(valid_a), 32'd0);
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd10), 1'b1, mk(3'b000, 32'd100, 32'd3, 5'd10));
    idle();

    // Same-cycle writeback to x7 while AND x8,x7,x7 is accepted.
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    e = mk(3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd8);
    e.op1_nb = 32'h1234_5678;
    e.op2_nb = 32'h1234_5678;
    issue(r_type(7'h00, 5'd7, 5'd7, 3'b111, 5'd8), 1'b1, e);
    wb_en = 1'b0;
    issue(r_type(7'h00, 5'd0, 5'd7, 3'b110, 5'd11), 1'b1, mk(3'b011, 32'hDEAD_BEEF, 32'd0, 5'd11));
    idle();

    // Illegal encodings: ECALL right behind a legal op, then two more.
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd16), 1'b1, mk(3'b000, 32'd100, 32'd3, 5'd16));
    issue(32'h0000_0073, 1'b0, e);
    check("ecall_illegal", 32'(ill_a), 32'd1);
    check("ecall_valid", 32'(valid_a), 32'd0);
    issue(r_type(7'h20, 5'd2, 5'd1, 3'b111, 5'd18), 1'b0, e);
    check("badsub_illegal", 32'(ill_a), 32'd1);
    idle();
    check("illegal_pulse_end", 32'(ill_a), 32'd0);
    issue(i_type(12'h001, 5'd1, 3'b001, 5'd19), 1'b0, e);
    idle();

    // Writes to x0 are ignored.
    write_reg(5'd0, 32'h0000_FFFF);
    issue(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd12), 1'b1, mk(3'b000, 32'd0, 32'd0, 5'd12));
    idle();

    // Reset while an operation is stalled on the output.
    alu_ready = 1'b0;
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd13), 1'b1, mk(3'b000, 32'd100, 32'd3, 5'd13));
    instr_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid_a", 32'(valid_a), 32'd0);
    check("midrst_valid_b", 32'(valid_b), 32'd0);
    check("midrst_op1", op1_a, 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd77;
    tick();
    tick();
    wb_en = 1'b0;
    rst = 1'b0;
    alu_ready = 1'b1;
    check("ready_after_midrst", 32'(ready_a), 32'd1);
    issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), 1'b1, mk(3'b000, 32'd0, 32'd0, 5'd14));
    issue(r_type(7'h00, 5'd7, 5'd7, 3'b111, 5'd15), 1'b1, mk(3'b010, 32'd0, 32'd0, 5'd15));
    idle();
    tick();
    tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("illegal_count_a", 32'(ill_seen_a), 32'(ill_exp));
    check("illegal_count_b", 32'(ill_seen_b), 32'(ill_exp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter BYPASS, default 1: when 1, a same-cycle writeback is forwarded to the operand read; when 0, no forwarding.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr_valid  input  1  instr holds an instruction.
REQ-005 instr_ready  output  1  stage can accept an instruction this cycle.
REQ-006 instr  input  32  RV32 instruction word.
REQ-007 wb_en  input  1  writeback strobe.
REQ-008 wb_rd  input  5  writeback destination register.
REQ-009 wb_data  input  32  writeback value.
REQ-010 alu_valid  output  1  ALU-side outputs hold a decoded operation.
REQ-011 alu_ready  input  1  ALU consumes the operation this cycle.
REQ-012 alu_func  output  3  ALU op code: 000 add, 001 sub, 010 and, 011 or.
REQ-013 alu_op1  output  32  first operand, value of rs1.
REQ-014 alu_op2  output  32  second operand, value of rs2 or sign-extended immediate.
REQ-015 alu_rd  output  5  destination register, carried with the operation.
REQ-016 illegal  output  1  one-cycle pulse when an unsupported instruction is consumed.

Function
REQ-017 The register file SHALL hold 32 x 32-bit registers; x0 reads 0; writes to x0 are ignored.
REQ-018 When wb_en=1 and wb_rd!=0, wb_data SHALL be written to register wb_rd on the rising clock edge.
REQ-019 Operand reads SHALL be combinational from instr[19:15] (rs1) and instr[24:20] (rs2) in the acceptance cycle.
REQ-020 With BYPASS=1: a read of rs (rs!=0) SHALL return wb_data when wb_en=1 and wb_rd==rs in the same cycle. With BYPASS=0: the read SHALL return the pre-write value.
REQ-021 Decode, opcode 0110011 (R-type), funct7/funct3: 0000000/000 ADD->000; 0100000/000 SUB->001; 0000000/111 AND->010; 0000000/110 OR->011; op2=rs2.
REQ-022 Decode, opcode 0010011 (I-type), funct3: 000 ADDI->000; 111 ANDI->010; 110 ORI->011; op2 = instr[31:20] sign-extended to 32 bits.
REQ-023 Every other encoding SHALL be illegal.
REQ-024 instr_ready SHALL equal (!alu_valid || alu_ready), combinationally.
REQ-025 Accept = instr_valid && instr_ready. A legal accept SHALL load alu_func/op1/op2/rd, with alu_rd = instr[11:7], and set alu_valid=1 on the next edge. Latency is 1 cycle.
REQ-026 An illegal accept SHALL NOT load the output register. The instruction is dropped. illegal SHALL be 1 for exactly the following cycle. alu_valid SHALL clear if the held operation is consumed in that cycle.
REQ-027 alu_valid && alu_ready with no legal accept in the same cycle SHALL clear alu_valid on the next edge.
REQ-028 Simultaneous consume and legal accept SHALL replace the output register, with alu_valid staying 1. Back-to-back throughput is 1 op per cycle.
REQ-029 While alu_valid && !alu_ready, alu_func/op1/op2/rd SHALL hold stable, and a later writeback SHALL NOT alter held operands.
REQ-030 Writeback SHALL proceed independently of stalls and of instr_valid.

Reset
REQ-031 While rst=1, alu_valid, illegal, alu_func, alu_op1, alu_op2, alu_rd and all 32 registers SHALL be 0, asynchronously.
REQ-032 Reset asserted mid-operation SHALL discard any held operation without a handshake. No writeback SHALL occur while rst=1.
REQ-033 instr_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Write x1=5 and x2=3, then ADD x3,x1,x2 with alu_ready=1 -> next cycle alu_valid=1, func=000, op1=5, op2=3, rd=3.
REQ-035 ADDI x4,x1,-1 (imm 0xFFF) with x1=5 -> op2=0xFFFFFFFF, func=000. ORI x5,x0,0x0F0 -> op1=0, op2=0x000000F0, func=011.
REQ-036 Hold alu_ready=0 for 3 cycles after SUB x6,x1,x2 -> instr_ready=0, outputs stable with func=001. Assert alu_ready -> alu_valid clears the next cycle if there is no new instruction.
REQ-037 Same cycle: wb_en=1, wb_rd=7, wb_data=0xDEADBEEF, and AND x8,x7,x7 accepted. BYPASS=1 -> op1=op2=0xDEADBEEF. BYPASS=0 -> old x7 value.
REQ-038 instr=0x00000073 (ECALL) accepted -> illegal=1 for one cycle, alu_valid unchanged. Writes to x0 followed by a read of x0 -> 0.
REQ-039 Assert rst while alu_valid=1 and alu_ready=0 -> alu_valid=0 immediately and all registers read 0 after release.
